// File: rtl/approx_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : approx_adder_pipe
//  Description : Pipelined lower-part-OR approximate adder with a runtime
//                approximation level, per-result exact error output and
//                on-block error/operation statistics. The carry chain is cut
//                into NUM_STAGES registered segments behind a single global
//                stall (valid/ready) handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_adder_pipe #(
    parameter int WIDTH         = 32,
    parameter int NUM_STAGES    = 2,
    parameter int MAX_APPROX_LV = 16,
    parameter int LV_W          = $clog2(MAX_APPROX_LV + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [LV_W-1:0]  approx_lv,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c,
    output logic [WIDTH-1:0] err,
    input  logic             stat_clear,
    output logic [31:0]      stat_ops,
    output logic [63:0]      stat_err
);

    localparam int SEG = WIDTH / NUM_STAGES;

    // Index s of these arrays is the input of stage s; index NUM_STAGES of
    // the result-carrying arrays is the output of the last stage.
    logic [NUM_STAGES:0] w_v;
    logic [NUM_STAGES:0] w_cy;
    logic [WIDTH-1:0]    w_sum [NUM_STAGES+1];
    logic [WIDTH-1:0]    w_err [NUM_STAGES+1];
    logic [WIDTH-1:0]    w_a   [NUM_STAGES];
    logic [WIDTH-1:0]    w_b   [NUM_STAGES];
    logic [LV_W-1:0]     w_k   [NUM_STAGES];

    logic                w_adv;
    logic [LV_W-1:0]     w_k_sat;
    logic [64:0]         w_err_acc;

    logic [31:0]         stat_ops_q;
    logic [63:0]         stat_err_q;

    // Whole pipe moves together whenever the output slot is free or draining.
    assign w_adv   = !w_v[NUM_STAGES] || o_ready;
    assign i_ready = w_adv;

    // Levels above the honoured maximum are clamped silently.
    assign w_k_sat = (approx_lv > LV_W'(MAX_APPROX_LV)) ? LV_W'(MAX_APPROX_LV) : approx_lv;

    assign w_v[0]   = i_valid;
    assign w_cy[0]  = 1'b0;
    assign w_sum[0] = '0;
    assign w_err[0] = '0;
    assign w_a[0]   = a;
    assign w_b[0]   = b;
    assign w_k[0]   = w_k_sat;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        localparam int LO = s * SEG;
        localparam int HI = LO + SEG;

        logic             v_q;
        logic             cy_q;
        logic             cy_d;
        logic [WIDTH-1:0] sum_q;
        logic [WIDTH-1:0] sum_d;
        logic [WIDTH-1:0] err_q;
        logic [WIDTH-1:0] err_d;

        // Segment bits below k are OR-ed (carry killed, error = a&b); the
        // rest ripple exactly, starting from a zero carry at bit k.
        always_comb begin
            sum_d = w_sum[s];
            err_d = w_err[s];
            cy_d  = w_cy[s];
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= LO && i < HI) begin
                    if (i < int'(w_k[s])) begin
                        sum_d[i] = w_a[s][i] | w_b[s][i];
                        err_d[i] = w_a[s][i] & w_b[s][i];
                        cy_d     = 1'b0;
                    end else begin
                        sum_d[i] = w_a[s][i] ^ w_b[s][i] ^ cy_d;
                        cy_d     = (w_a[s][i] & w_b[s][i]) | (cy_d & (w_a[s][i] ^ w_b[s][i]));
                    end
                end
            end
        end

        // Stage result register; bubbles move along with real operations.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v_q   <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
                err_q <= '0;
            end else if (w_adv) begin
                v_q   <= w_v[s];
                cy_q  <= cy_d;
                sum_q <= sum_d;
                err_q <= err_d;
            end
        end

        assign w_v[s+1]   = v_q;
        assign w_cy[s+1]  = cy_q;
        assign w_sum[s+1] = sum_q;
        assign w_err[s+1] = err_q;

        if (s < NUM_STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [LV_W-1:0]  k_q;

            // Operands and level travel with the partial result to the next segment.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    k_q <= '0;
                end else if (w_adv) begin
                    a_q <= w_a[s];
                    b_q <= w_b[s];
                    k_q <= w_k[s];
                end
            end

            assign w_a[s+1] = a_q;
            assign w_b[s+1] = b_q;
            assign w_k[s+1] = k_q;
        end
    end

    assign o_valid = w_v[NUM_STAGES];
    assign sum     = w_sum[NUM_STAGES];
    assign c       = w_cy[NUM_STAGES];
    assign err     = w_err[NUM_STAGES];

    // One spare bit catches overflow of the error accumulator.
    assign w_err_acc = {1'b0, stat_err_q} + 65'(w_err[NUM_STAGES]);

    // Statistics count output transfers; clear wins over a same-cycle transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_ops_q <= '0;
            stat_err_q <= '0;
        end else if (stat_clear) begin
            stat_ops_q <= '0;
            stat_err_q <= '0;
        end else if (w_v[NUM_STAGES] && o_ready) begin
            stat_ops_q <= stat_ops_q + 32'd1;
            stat_err_q <= w_err_acc[64] ? {64{1'b1}} : w_err_acc[63:0];
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_err = stat_err_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_approx_adder_pipe
//  Description : Self-checking bench for approx_adder_pipe: directed vector
//                table, stalled random burst with scoreboard, statistics
//                clear priority and mid-flight reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_adder_pipe;

    localparam int WIDTH         = 32;
    localparam int NUM_STAGES    = 2;
    localparam int MAX_APPROX_LV = 16;
    localparam int LV_W          = $clog2(MAX_APPROX_LV + 1);

    logic             clk;
    logic             reset_n;
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [LV_W-1:0]  approx_lv;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] sum;
    logic             c;
    logic [WIDTH-1:0] err;
    logic             stat_clear;
    logic [31:0]      stat_ops;
    logic [63:0]      stat_err;

    int checks   = 0;
    int failures = 0;

    approx_adder_pipe #(
        .WIDTH         (WIDTH),
        .NUM_STAGES    (NUM_STAGES),
        .MAX_APPROX_LV (MAX_APPROX_LV),
        .LV_W          (LV_W)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .a          (a),
        .b          (b),
        .approx_lv  (approx_lv),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .sum        (sum),
        .c          (c),
        .err        (err),
        .stat_clear (stat_clear),
        .stat_ops   (stat_ops),
        .stat_err   (stat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  lv;
        logic [31:0] s;
        logic        c;
        logic [31:0] e;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic [31:0] e;
    } res_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact sum minus the dropped carries (a & b in the low k bits).
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [4:0] lv,
                         output logic [31:0] ms, output logic mc, output logic [31:0] me);
        logic [32:0] exact;
        logic [32:0] mask;
        logic [32:0] approx;
        int k;
        k      = (int'(lv) > MAX_APPROX_LV) ? MAX_APPROX_LV : int'(lv);
        exact  = {1'b0, ma} + {1'b0, mb};
        mask   = (33'h1 << k) - 33'h1;
        me     = ma & mb & mask[31:0];
        approx = exact - {1'b0, me};
        ms     = approx[31:0];
        mc     = approx[32];
    endtask

    // Issue one operation with o_ready high and check latency and result.
    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic [4:0] lv, input logic [31:0] es, input logic ec,
                          input logic [31:0] ee);
        int lat;
        o_ready   = 1'b1;
        i_valid   = 1'b1;
        a         = ta;
        b         = tb_;
        approx_lv = lv;
        chk({name, "_iready"}, 64'(i_ready), 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(NUM_STAGES));
        chk({name, "_sum"}, 64'(sum), 64'(es));
        chk({name, "_c"},   64'(c),   64'(ec));
        chk({name, "_err"}, 64'(err), 64'(ee));
        @(posedge clk); #1;
    endtask

    vec_t        vecs [10];
    logic [31:0] ba   [10];
    logic [31:0] bb   [10];
    logic [4:0]  blv  [10];
    res_t        q    [$];
    res_t        r;
    res_t        h;
    logic [63:0] err_total;
    int          idx;
    int          got;
    int          cyc;
    int          stall_seen;
    int          stale;
    int          wt;

    initial begin
        //            a             b             lv     sum           c     err
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 32'h00000000};
        vecs[1] = '{32'h0000000F, 32'h00000001, 5'd4,  32'h0000000F, 1'b0, 32'h00000001};
        vecs[2] = '{32'h0000FFFF, 32'h0000FFFF, 5'd31, 32'h0000FFFF, 1'b0, 32'h0000FFFF};
        vecs[3] = '{32'h12345678, 32'h11111111, 5'd0,  32'h23456789, 1'b0, 32'h00000000};
        vecs[4] = '{32'h000000FF, 32'h000000FF, 5'd8,  32'h000000FF, 1'b0, 32'h000000FF};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 32'hFFFEFFFF, 1'b1, 32'h0000FFFF};
        vecs[6] = '{32'h00000001, 32'h00000001, 5'd1,  32'h00000001, 1'b0, 32'h00000001};
        vecs[7] = '{32'h80008000, 32'h80008000, 5'd17, 32'h00008000, 1'b1, 32'h00008000};
        vecs[8] = '{32'h00008000, 32'h00008000, 5'd15, 32'h00010000, 1'b0, 32'h00000000};
        vecs[9] = '{32'h00010000, 32'h0000FFFF, 5'd16, 32'h0001FFFF, 1'b0, 32'h00000000};

        reset_n    = 1'b0;
        i_valid    = 1'b0;
        o_ready    = 1'b1;
        a          = '0;
        b          = '0;
        approx_lv  = '0;
        stat_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        chk("rst_o_valid",  64'(o_valid),  64'd0);
        chk("rst_i_ready",  64'(i_ready),  64'd1);
        chk("rst_sum",      64'(sum),      64'd0);
        chk("rst_c",        64'(c),        64'd0);
        chk("rst_err",      64'(err),      64'd0);
        chk("rst_stat_ops", 64'(stat_ops), 64'd0);
        chk("rst_stat_err", stat_err,      64'd0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lv,
                   vecs[i].s, vecs[i].c, vecs[i].e);
            if (i == 0) begin
                chk("vec0_stat_ops", 64'(stat_ops), 64'd1);
                chk("vec0_stat_err", stat_err,      64'd0);
            end
        end
        chk("table_stat_ops", 64'(stat_ops), 64'd10);
        chk("table_stat_err", stat_err,      64'h280FF);

        // Random burst with o_ready low for cycles 3..7
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ba[i]  = $urandom;
            bb[i]  = $urandom;
            blv[i] = 5'($urandom_range(0, 16));
        end
        idx = 0; got = 0; cyc = 0; stall_seen = 0; err_total = '0;
        while (got < 10 && cyc < 200) begin
            o_ready = !(cyc >= 3 && cyc <= 7);
            if (idx < 10) begin
                i_valid   = 1'b1;
                a         = ba[idx];
                b         = bb[idx];
                approx_lv = blv[idx];
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            if (!i_ready) stall_seen = 1;
            if (o_valid && o_ready) begin
                if (q.size() == 0) begin
                    chk($sformatf("burst_unexpected_%0d", got), 64'd1, 64'd0);
                end else begin
                    h = q.pop_front();
                    chk($sformatf("burst%0d_sum", got), 64'(sum), 64'(h.s));
                    chk($sformatf("burst%0d_c", got),   64'(c),   64'(h.c));
                    chk($sformatf("burst%0d_err", got), 64'(err), 64'(h.e));
                end
                got++;
            end
            if (i_valid && i_ready) begin
                model(ba[idx], bb[idx], blv[idx], r.s, r.c, r.e);
                q.push_back(r);
                err_total = err_total + 64'(r.e);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        chk("burst_results",  64'(got),        64'd10);
        chk("burst_stall",    64'(stall_seen), 64'd1);
        chk("burst_stat_ops", 64'(stat_ops),   64'd10);
        chk("burst_stat_err", stat_err,        err_total);

        // stat_clear has priority over a same-cycle transfer with err=5
        o_ready   = 1'b0;
        i_valid   = 1'b1;
        a         = 32'h5;
        b         = 32'h5;
        approx_lv = 5'd4;
        @(posedge clk); #1;
        i_valid = 1'b0;
        wt = 0;
        while (!o_valid && wt < 20) begin
            @(posedge clk); #1;
            wt++;
        end
        chk("clr_wait", 64'(o_valid), 64'd1);
        chk("clr_err",  64'(err),     64'd5);
        chk("clr_sum",  64'(sum),     64'd5);
        o_ready    = 1'b1;
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        chk("clr_stat_ops", 64'(stat_ops), 64'd0);
        chk("clr_stat_err", stat_err,      64'd0);

        // Reset with two operations in flight
        i_valid   = 1'b1;
        a         = 32'h1;
        b         = 32'h2;
        approx_lv = 5'd0;
        @(posedge clk); #1;
        a = 32'h3;
        b = 32'h4;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("pre_reset_valid", 64'(o_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("reset_o_valid", 64'(o_valid), 64'd0);
        chk("reset_sum",     64'(sum),     64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_valid) stale++;
        end
        @(posedge clk); #1;
        chk("post_reset_stale",    64'(stale),    64'd0);
        chk("post_reset_stat_ops", 64'(stat_ops), 64'd0);
        run_op("post_reset_op", 32'h00000100, 32'h00000207, 5'd3,
               32'h00000307, 1'b0, 32'h00000000);
        run_op("post_reset_op2", 32'h0000000E, 32'h0000000B, 5'd3,
               32'h00000017, 1'b0, 32'h00000002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
